// File: rtl/load_sequencer.sv
// Load sequencer: turns one Memory-stage load into one or two aligned reads, then aligns and extends the data.
// Latency: accept N, MemReq N+1, ResultValid N+2 when aligned with same-cycle ack; +1 per extra read or ack wait.
// Backpressure: LoadReady only in IDLE, Stall holds the pipeline; MISALIGNED_LOAD_EN enables split reads.

`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

package load_sequencer_pkg;
    typedef enum logic [2:0] {
        NO_TRUNC           = 3'd0,
        BYTE               = 3'd1,
        HALF_WORD          = 3'd2,
        WORD               = 3'd3,
        BYTE_UNSIGNED      = 3'd4,
        HALF_WORD_UNSIGNED = 3'd5,
        WORD_UNSIGNED      = 3'd6
    } trunc_src_t;
endpackage

module load_sequencer
    import load_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  LoadValid,
    output logic                  LoadReady,
    input  logic [`BIT_COUNT-1:0] LoadAddr,
    input  logic [2:0]            TruncSrc,
    output logic                  MemReq,
    output logic [`BIT_COUNT-1:0] MemAddr,
    input  logic                  MemAck,
    input  logic [`BIT_COUNT-1:0] MemRdata,
    output logic                  ResultValid,
    output logic [`BIT_COUNT-1:0] Result,
    output logic                  Fault,
    output logic                  Stall
);
    localparam int W     = `BIT_COUNT;
    localparam int BYTES = W / 8;
    localparam int OW    = $clog2(BYTES);
    localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0]  ALIGN_MASK = ~W'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    addr_q;
    logic [2:0]      trunc_q;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            fault_q, fault_nxt;
    logic [W-1:0]    lo_q;
    logic            lo_ld;
    logic [2*W-1:0]  pair;
    logic [W-1:0]    shifted;

    // Unknown encodings fall through to the full-word size.
    function automatic int size_bytes(input logic [2:0] t);
        case (t)
            BYTE, BYTE_UNSIGNED:           size_bytes = 1;
            HALF_WORD, HALF_WORD_UNSIGNED: size_bytes = 2;
            WORD, WORD_UNSIGNED:           size_bytes = 4;
            default:                       size_bytes = BYTES;
        endcase
    endfunction

    function automatic logic is_split(input logic [OW-1:0] off, input logic [2:0] t);
        is_split = (int'(off) + size_bytes(t)) > BYTES;
    endfunction

    function automatic logic [W-1:0] truncate(input logic [W-1:0] v, input logic [2:0] t);
        case (t)
            BYTE:               truncate = W'($signed(v[7:0]));
            BYTE_UNSIGNED:      truncate = W'(v[7:0]);
            HALF_WORD:          truncate = W'($signed(v[15:0]));
            HALF_WORD_UNSIGNED: truncate = W'(v[15:0]);
            WORD:               truncate = W'($signed(v[31:0]));
            WORD_UNSIGNED:      truncate = W'(v[31:0]);
            default:            truncate = v;
        endcase
    endfunction

`ifdef MISALIGNED_LOAD_EN
    logic [W-1:0] hi_q;
    logic         hi_ld;
    assign pair = {hi_q, lo_q};
`else
    assign pair = {{W{1'b0}}, lo_q};
`endif

    assign shifted = W'(pair >> {addr_q[OW-1:0], 3'b000});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            trunc_q <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            lo_q    <= '0;
        end else begin
            state   <= state_nxt;
            cnt_q   <= cnt_nxt;
            fault_q <= fault_nxt;
            if (state == IDLE && LoadValid) begin
                addr_q  <= LoadAddr;
                trunc_q <= TruncSrc;
            end
            if (lo_ld) lo_q <= MemRdata;
        end
    end

`ifdef MISALIGNED_LOAD_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   hi_q <= '0;
        else if (hi_ld) hi_q <= MemRdata;
    end
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_q;
        fault_nxt   = fault_q;
        lo_ld       = 1'b0;
`ifdef MISALIGNED_LOAD_EN
        hi_ld       = 1'b0;
`endif
        LoadReady   = 1'b0;
        MemReq      = 1'b0;
        MemAddr     = '0;
        ResultValid = 1'b0;
        Result      = '0;
        Fault       = 1'b0;
        Stall       = 1'b0;
        unique case (state)
            IDLE: begin
                LoadReady = 1'b1;
                Stall     = LoadValid;
                if (LoadValid) begin
                    cnt_nxt   = '0;
                    fault_nxt = 1'b0;
                    state_nxt = REQ_LO;
`ifndef MISALIGNED_LOAD_EN
                    // Without split support a straddling load faults without touching memory.
                    if (is_split(LoadAddr[OW-1:0], TruncSrc)) begin
                        state_nxt = DONE;
                        fault_nxt = 1'b1;
                    end
`endif
                end
            end
            REQ_LO: begin
                MemReq  = 1'b1;
                MemAddr = addr_q & ALIGN_MASK;
                Stall   = 1'b1;
                if (MemAck) begin
                    lo_ld   = 1'b1;
                    cnt_nxt = '0;
`ifdef MISALIGNED_LOAD_EN
                    state_nxt = is_split(addr_q[OW-1:0], trunc_q) ? REQ_HI : DONE;
`else
                    state_nxt = DONE;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = DONE;
                    fault_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            REQ_HI: begin
`ifdef MISALIGNED_LOAD_EN
                MemReq  = 1'b1;
                MemAddr = (addr_q & ALIGN_MASK) + W'(BYTES);
                Stall   = 1'b1;
                if (MemAck) begin
                    hi_ld     = 1'b1;
                    state_nxt = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = DONE;
                    fault_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
`else
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                ResultValid = 1'b1;
                Fault       = fault_q;
                Result      = fault_q ? '0 : truncate(shifted, trunc_q);
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer with a two-word memory model and configurable ack delay.
module tb_load_sequencer;
    import load_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        LoadValid;
    logic        LoadReady;
    logic [31:0] LoadAddr;
    logic [2:0]  TruncSrc;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRdata;
    logic        ResultValid;
    logic [31:0] Result;
    logic        Fault;
    logic        Stall;

    logic ack_en    = 1'b1;
    logic ack_force = 1'b0;
    int   ack_delay = 0;
    int   wait_cnt  = 0;
    int   n_assert  = 0;
    int   n_fail    = 0;

    load_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .LoadValid(LoadValid), .LoadReady(LoadReady),
        .LoadAddr(LoadAddr), .TruncSrc(TruncSrc), .MemReq(MemReq), .MemAddr(MemAddr),
        .MemAck(MemAck), .MemRdata(MemRdata), .ResultValid(ResultValid), .Result(Result),
        .Fault(Fault), .Stall(Stall)
    );

    always #5 clk = ~clk;

    // Memory answers after ack_delay cycles of continuous request.
    assign MemAck   = ack_force | (MemReq & ack_en & (wait_cnt >= ack_delay));
    assign MemRdata = (MemAddr == 32'h1000) ? 32'h44332211 :
                      (MemAddr == 32'h1004) ? 32'h88776655 : 32'h0;

    always @(posedge clk) begin
        if (MemReq && !MemAck) wait_cnt <= wait_cnt + 1;
        else                   wait_cnt <= 0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one load; lat counts cycles from acceptance edge to the ResultValid cycle.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] ts,
                            input int exp_lat, input int exp_nreq,
                            input logic [31:0] exp_a0, input logic [31:0] exp_a1,
                            input logic [31:0] exp_res, input logic exp_fault);
        int          lat;
        int          nreq;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        seen;
        @(negedge clk);
        check1({tag, "/ready"}, LoadReady, 1'b1);
        LoadValid = 1'b1;
        LoadAddr  = addr;
        TruncSrc  = ts;
        #1;
        check1({tag, "/stall_accept"}, Stall, 1'b1);
        @(negedge clk);
        LoadValid = 1'b0;
        lat  = 1;
        nreq = 0;
        a0   = '0;
        a1   = '0;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (ResultValid) begin
                seen = 1'b1;
            end else begin
                if (MemReq) begin
                    if (nreq == 0) a0 = MemAddr;
                    else           a1 = MemAddr;
                    nreq++;
                    check1({tag, "/stall_busy"}, Stall, 1'b1);
                end
                lat++;
                @(negedge clk);
            end
        end
        check1({tag, "/result_valid_seen"}, seen, 1'b1);
        checki({tag, "/latency"}, lat, exp_lat);
        checki({tag, "/mem_requests"}, nreq, exp_nreq);
        if (exp_nreq > 0) check32({tag, "/first_addr"}, a0, exp_a0);
        if (exp_nreq > 1) check32({tag, "/last_addr"}, a1, exp_a1);
        check32({tag, "/result"}, Result, exp_res);
        check1({tag, "/fault"}, Fault, exp_fault);
        check1({tag, "/stall_done"}, Stall, 1'b0);
        @(negedge clk);
        check1({tag, "/pulse_ends"}, ResultValid, 1'b0);
        check1({tag, "/back_idle"}, LoadReady, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "/ready"}, LoadReady, 1'b1);
        check1({tag, "/memreq"}, MemReq, 1'b0);
        check32({tag, "/memaddr"}, MemAddr, 32'h0);
        check1({tag, "/rvalid"}, ResultValid, 1'b0);
        check32({tag, "/result"}, Result, 32'h0);
        check1({tag, "/fault"}, Fault, 1'b0);
        check1({tag, "/stall"}, Stall, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        LoadValid = 1'b0;
        LoadAddr  = '0;
        TruncSrc  = '0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_load("lw_1000",  32'h1000, WORD,               2, 1, 32'h1000, 32'h0, 32'h44332211, 1'b0);
        run_load("lh_1006",  32'h1006, HALF_WORD,          2, 1, 32'h1004, 32'h0, 32'hFFFF8877, 1'b0);
        run_load("lbu_1003", 32'h1003, BYTE_UNSIGNED,      2, 1, 32'h1000, 32'h0, 32'h00000044, 1'b0);
        run_load("lb_1007",  32'h1007, BYTE,               2, 1, 32'h1004, 32'h0, 32'hFFFFFF88, 1'b0);
        run_load("lb_1001",  32'h1001, BYTE,               2, 1, 32'h1000, 32'h0, 32'h00000022, 1'b0);
        run_load("lhu_1006", 32'h1006, HALF_WORD_UNSIGNED, 2, 1, 32'h1004, 32'h0, 32'h00008877, 1'b0);
        run_load("ld_1004",  32'h1004, NO_TRUNC,           2, 1, 32'h1004, 32'h0, 32'h88776655, 1'b0);

`ifdef MISALIGNED_LOAD_EN
        run_load("lw_1002",  32'h1002, WORD,      3, 2, 32'h1000, 32'h1004, 32'h66554433, 1'b0);
        run_load("lh_1003",  32'h1003, HALF_WORD, 3, 2, 32'h1000, 32'h1004, 32'h00005544, 1'b0);
`else
        run_load("lw_1002",  32'h1002, WORD,      1, 0, 32'h0, 32'h0, 32'h0, 1'b1);
        run_load("lh_1003",  32'h1003, HALF_WORD, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1);
`endif

        // Ack arriving on the last allowed wait cycle beats the timeout.
        ack_delay = 3;
        run_load("slow_ack", 32'h1000, WORD, 5, 4, 32'h1000, 32'h1000, 32'h44332211, 1'b0);
        ack_delay = 0;

        ack_en = 1'b0;
        run_load("timeout",  32'h1000, WORD, 5, 4, 32'h1000, 32'h1000, 32'h0, 1'b1);
        check1("timeout/memreq_low", MemReq, 1'b0);

        // Reset in the middle of an access, followed by a stray ack.
        @(negedge clk);
`ifdef MISALIGNED_LOAD_EN
        ack_en   = 1'b1;
        LoadAddr = 32'h1002;
`else
        ack_en   = 1'b0;
        LoadAddr = 32'h1000;
`endif
        LoadValid = 1'b1;
        TruncSrc  = WORD;
        @(negedge clk);
        LoadValid = 1'b0;
        check1("midrst/lo_req", MemReq, 1'b1);
        check32("midrst/lo_addr", MemAddr, 32'h1000);
`ifdef MISALIGNED_LOAD_EN
        @(posedge clk);
        #1 ack_en = 1'b0;
        @(negedge clk);
        check1("midrst/hi_req", MemReq, 1'b1);
        check32("midrst/hi_addr", MemAddr, 32'h1004);
`endif
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset_n   = 1'b1;
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("late_ack/rvalid", ResultValid, 1'b0);
            check1("late_ack/memreq", MemReq, 1'b0);
            check1("late_ack/ready", LoadReady, 1'b1);
            @(negedge clk);
        end
        ack_en = 1'b1;
        run_load("after_rst", 32'h1000, WORD, 2, 1, 32'h1000, 32'h0, 32'h44332211, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles MemReq may stay high without MemAck before the load is aborted with Fault.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 LoadValid  input  1  load request from Memory stage.
REQ-005 LoadReady  output  1  sequencer can accept a request; high only in IDLE.
REQ-006 LoadAddr  input  `BIT_COUNT  byte address of load.
REQ-007 TruncSrc  input  truncSrc  load size/signedness (HighLevelControl enum).
REQ-008 MemReq  output  1  memory read request, held until MemAck.
REQ-009 MemAddr  output  `BIT_COUNT  read address, aligned to `BIT_COUNT/8 bytes.
REQ-010 MemAck  input  1  memory returns MemRdata this cycle.
REQ-011 MemRdata  input  `BIT_COUNT  read data, little-endian.
REQ-012 ResultValid  output  1  one-cycle pulse: Result/Fault valid.
REQ-013 Result  output  `BIT_COUNT  aligned, sign/zero-extended load value.
REQ-014 Fault  output  1  load aborted (misaligned-disabled or timeout); qualified by ResultValid.
REQ-015 Stall  output  1  high from request acceptance until the cycle before ResultValid; holds pipeline.

Function
REQ-016 States: IDLE, REQ_LO, REQ_HI, DONE; encoded as an enum.
REQ-017 IDLE: LoadValid=1 captures LoadAddr, TruncSrc; next REQ_LO (or DONE with fault per REQ-025).
REQ-018 Size: BYTE/BYTE_UNSIGNED=1, HALF_WORD/HALF_WORD_UNSIGNED=2, WORD/WORD_UNSIGNED=4, NO_TRUNC=`BIT_COUNT/8 bytes; offset = LoadAddr low log2(`BIT_COUNT/8) bits.
REQ-019 Split when offset+size > `BIT_COUNT/8; otherwise single access.
REQ-020 REQ_LO: MemReq=1, MemAddr=aligned LoadAddr; on MemAck capture lo word, next REQ_HI if split else DONE.
REQ-021 REQ_HI: MemReq=1, MemAddr=aligned LoadAddr + `BIT_COUNT/8 (wraps modulo 2^`BIT_COUNT); on MemAck capture hi word, next DONE.
REQ-022 DONE: ResultValid=1 one cycle; Result = ({hi,lo} >> 8*offset) low `BIT_COUNT bits, passed through truncator with captured TruncSrc; next IDLE.
REQ-023 Latency, aligned, ack same cycle as request: accept at cycle N, MemReq N+1, ResultValid N+2; split adds one cycle per extra access.
REQ-024 MemReq deasserts the cycle after MemAck; MemAck outside REQ_LO/REQ_HI is ignored.
REQ-025 Timeout counter resets on entering REQ_LO/REQ_HI, increments each cycle without MemAck; at TIMEOUT_CYCLES go DONE with Fault=1, Result=0.
REQ-026 LoadValid while not IDLE is ignored; requester holds request until LoadReady.
REQ-027 Invalid TruncSrc encoding: treated as NO_TRUNC size; Result is don't-care.

Reset
REQ-028 reset_n low: state IDLE immediately; LoadReady=1; MemReq, ResultValid, Fault, Stall=0; Result, MemAddr=0; counter and captured words cleared.
REQ-029 Reset mid-access abandons the load; no ResultValid is produced for it; a late MemAck after reset release is ignored in IDLE.

Configuration
REQ-030 Macro MISALIGNED_LOAD_EN defined: split accesses per REQ-019..021.
REQ-031 Macro undefined: split-condition loads issue no MemReq, go IDLE->DONE, ResultValid=1 with Fault=1, Result=0; REQ_HI state and hi-word register not synthesized.

Verification (BIT_COUNT=32, mem[0x1000]=0x44332211, mem[0x1004]=0x88776655, ack same cycle unless noted)
REQ-032 LW 0x1000 -> one MemReq at 0x1000, ResultValid 2 cycles after accept, Result=0x44332211, Fault=0.
REQ-033 LH 0x1006 -> MemAddr 0x1004, Result=0xFFFF8877; LBU 0x1003 -> Result=0x00000044.
REQ-034 LW 0x1002 with MISALIGNED_LOAD_EN -> MemReq 0x1000 then 0x1004, Result=0x66554433, 3 cycles after accept; without macro -> no MemReq, Fault=1, Result=0.
REQ-035 LW 0x1000, MemAck never asserted, TIMEOUT_CYCLES=4 -> ResultValid with Fault=1 after 4 wait cycles, MemReq then 0, back to IDLE.
REQ-036 reset_n low during REQ_HI, then MemAck after release -> all outputs at reset values, no ResultValid, next LoadValid accepted normally.
